load_store_unit: RTL and testbench

Initiator-side memory access unit between the MEM pipeline stage and the word-addressed data memory. It accepts one load or store request at a time and issues the corresponding read and write cycles to the memory. It performs byte and halfword stores by read-modify-write and sign- or zero-extends sub-word loads. Misaligned or illegal requests are answered with an error response and never reach memory.

---
 rtl/load_store_unit.sv | 83 ++++++++
 tb/tb_load_store_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator with sub-word RMW and load extension
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nxt;
  logic [31:0] addr_q, wdata_q, rbuf, merged, rdata_ext;
  logic [15:0] lane;
  logic [1:0] size_q;
  logic write_q, uns_q, err_q, req_err;
  assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  // state register; reset drops the enables immediately, so an interrupted write never lands
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // request latch and read buffer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rbuf    <= '0;
    end else if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      write_q <= req_write;
      uns_q   <= req_unsigned;
      err_q   <= req_err;
    end else if (state == READ) rbuf <= mem_rdata;
  // next state: errors skip memory, word stores skip the read
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = req_err ? RESP : (!req_write || req_size != 2'b10) ? READ : WRITE;
      READ:  state_nxt = write_q ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
    endcase
  end
  // little-endian lane merge of the store payload into the read buffer
  always_comb begin
    merged = rbuf;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged = wdata_q;
  end
  // load lane extraction; halfwords are aligned so the byte shift also serves them
  assign lane = 16'(rbuf >> {addr_q[1:0], 3'b000});
  always_comb
    rdata_ext = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane} : rbuf;
  // outputs decoded from state; everything idles at zero
  always_comb begin
    req_ready   = state == IDLE;
    mem_read    = state == READ;
    mem_write   = state == WRITE;
    mem_address = (state == READ || state == WRITE) ? {2'b00, addr_q[31:2]} : '0;
    mem_wdata   = state == WRITE ? merged : '0;
    resp_valid  = state == RESP;
    resp_error  = state == RESP && err_q;
    resp_rdata  = (state == RESP && !err_q && !write_q) ? rdata_ext : '0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a byte-level reference model
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_error, mem_write, mem_read;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int n_checks = 0, n_fail = 0;
  int cur = 0;
  int ph[$];
  logic [31:0] e_rdata, e_wword, e_addr;
  logic e_err;
  logic [7:0] widx;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_wdata;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: phase sequence per request kind, data computed byte by byte
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph.delete();
      cur = 0;
    end else begin
      if (cur == 2) ref_mem[widx] = e_wword;
      if (cur == 0 && req_valid) begin
        logic [31:0] old, v;
        int b, nb;
        b = int'(req_addr % 4);
        nb = 1 << req_size;
        widx = req_addr[9:2];
        e_addr = req_addr >> 2;
        old = ref_mem[widx];
        e_err = req_size == 3 || (req_size == 1 && req_addr % 2 != 0) || (req_size == 2 && req_addr % 4 != 0);
        e_rdata = '0;
        e_wword = old;
        if (e_err) ph.push_back(3);
        else if (!req_write) begin
          v = '0;
          for (int i = 0; i < nb; i++) v[8*i +: 8] = old[8*(b+i) +: 8];
          if (!req_unsigned && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
          e_rdata = v;
          ph.push_back(1); ph.push_back(3);
        end else begin
          for (int i = 0; i < nb; i++) e_wword[8*(b+i) +: 8] = req_wdata[8*i +: 8];
          if (nb < 4) ph.push_back(1);
          ph.push_back(2); ph.push_back(3);
        end
      end
      cur = ph.size() > 0 ? ph.pop_front() : 0;
    end
  end

  // per-cycle comparison of every output against the model phase
  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(cur == 0));
    check("mem_read", 32'(mem_read), 32'(cur == 1));
    check("mem_write", 32'(mem_write), 32'(cur == 2));
    check("mem_address", mem_address, (cur == 1 || cur == 2) ? e_addr : 32'h0);
    check("mem_wdata", mem_wdata, cur == 2 ? e_wword : 32'h0);
    check("resp_valid", 32'(resp_valid), 32'(cur == 3));
    check("resp_error", 32'(resp_error), 32'(cur == 3 && e_err));
    check("resp_rdata", resp_rdata, (cur == 3 && !e_err) ? e_rdata : 32'h0);
  end

  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic op(input string nm, input bit w, input logic [1:0] sz, input bit u,
                    input logic [31:0] a, d, input int lat, input logic [31:0] er, input bit ee);
    int n;
    bit found;
    issue(w, sz, u, a, d);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      n++;
      found = resp_valid;
    end
    check({nm, " latency"}, found ? n : 0, lat);
    check({nm, " rdata"}, resp_rdata, er);
    check({nm, " error"}, 32'(resp_error), 32'(ee));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    #1 rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'h1;
    repeat (3) begin
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'h1);
      check("rst mem_write", 32'(mem_write), 32'h0);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    check("rst no write", mem[2], 32'h0);
    op("sw 08", 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 2, 32'h0, 0);
    check("sw mem", mem[2], 32'hDEADBEEF);
    op("lw 08", 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'hDEADBEEF, 0);
    op("sb 09", 1, 2'b00, 0, 32'h09, 32'h123456A5, 3, 32'h0, 0);
    check("sb mem", mem[2], 32'hDEADA5EF);
    op("lb 09", 0, 2'b00, 0, 32'h09, 32'h0, 2, 32'hFFFFFFA5, 0);
    op("lbu 09", 0, 2'b00, 1, 32'h09, 32'h0, 2, 32'h000000A5, 0);
    op("lh 0a", 0, 2'b01, 0, 32'h0A, 32'h0, 2, 32'hFFFFDEAD, 0);
    op("lhu 0a", 0, 2'b01, 1, 32'h0A, 32'h0, 2, 32'h0000DEAD, 0);
    op("lh 08", 0, 2'b01, 0, 32'h08, 32'h0, 2, 32'hFFFFA5EF, 0);
    op("lw 06 err", 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0, 1);
    op("sh 03 err", 1, 2'b01, 0, 32'h03, 32'hFFFF, 1, 32'h0, 1);
    op("sz3 err", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1);
    check("err mem2", mem[2], 32'hDEADA5EF);
    check("err mem0", mem[0], 32'h0);
    op("sw 408 alias", 1, 2'b10, 0, 32'h408, 32'h11223344, 2, 32'h0, 0);
    op("lw 08 alias", 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'h11223344, 0);
    op("sb 0b", 1, 2'b00, 0, 32'h0B, 32'h00000055, 3, 32'h0, 0);
    op("lbu 0b", 0, 2'b00, 1, 32'h0B, 32'h0, 2, 32'h00000055, 0);
    op("sh 02", 1, 2'b01, 0, 32'h02, 32'h1234BEEF, 3, 32'h0, 0);
    op("lw 00", 0, 2'b10, 0, 32'h00, 32'h0, 2, 32'hBEEF0000, 0);
    op("lhu 02", 0, 2'b01, 1, 32'h02, 32'h0, 2, 32'h0000BEEF, 0);
    issue(1, 2'b01, 0, 32'h08, 32'h00007777);
    for (int i = 0; i < 8 && cur != 2; i++) @(negedge clk);
    check("reached write", 32'(cur), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("rst drops mem_write", 32'(mem_write), 32'h0);
    check("rst drops mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-rst req_ready", 32'(req_ready), 32'h1);
    check("aborted sh mem", mem[2], 32'h55223344);
    #2 rst = 1'b1;
    #1;
    check("idle rst req_ready", 32'(req_ready), 32'h1);
    check("idle rst resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op("lw 08 final", 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'h55223344, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
